mest_pro_imem_responder: RTL and testbench
==========================================

# mest_pro_imem_responder

Memory-side responder for the MEST Pro instruction/data memory bus. It decodes the processor's program-counter address, chip-select, write-enable and memory-reset strobes and serves registered read data back on the instruction bus. It reports illegal accesses on the error line and performs a full-array clear sequence on command. It sits between `mest_pro` and the storage array, at the far end of the processor's memory port.

## Interface
Parameters:
- `OP_CODE_SIZE`, 4, opcode field width; used only to derive `INSTRUCTION_SIZE`.
- `INSTRUCTION_SIZE`, `OP_CODE_SIZE+24` (28), word width.
- `ROM_DEPTH`, 65536, number of words; any value ≥ 2, not necessarily a power of two.
- `PROT_WORDS`, 16, size of the write-protected low region; used only with `MEST_IMEM_WRPROT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_addr` in `$clog2(ROM_DEPTH)`: word address (processor `o_prog_counter`).
- `i_in_dat` in `INSTRUCTION_SIZE`: write data (processor `data2store`).
- `i_cs` in 1: access strobe, one access per high cycle.
- `i_we` in 1: 1 = write, 0 = read; qualified by `i_cs`.
- `i_mem_reset` in 1: clear-array request (processor `RESET`).
- `o_dat` out `INSTRUCTION_SIZE`: registered read data.
- `o_error` out 1: one-cycle error pulse (processor `m_ERROR`).
- `o_busy` out 1: high while a clear sweep is running.

## Operation
- States: IDLE, CLEAR.
- Priority, evaluated each cycle: `i_mem_reset` first, then `i_cs`.

IDLE:
- `i_mem_reset` = 1: go to CLEAR, sweep counter = 0, `o_dat` ← 0.
- Read (`i_cs` & !`i_we`) with `i_addr` < `ROM_DEPTH`: `o_dat` ← mem[`i_addr`].
- Write (`i_cs` & `i_we`) with `i_addr` < `ROM_DEPTH`: mem[`i_addr`] ← `i_in_dat`; `o_dat` holds.
- Any access with `i_addr` ≥ `ROM_DEPTH`: no array access; `o_dat` holds; `o_error` pulses.
- `i_cs` = 0: `o_dat` holds; no array access.

CLEAR:
- Each cycle writes 0 to mem[counter], then counter++.
- After writing index `ROM_DEPTH-1`, return to IDLE; the counter does not wrap.
- `i_mem_reset` = 1 during CLEAR: counter restarts at 0 and the state stays CLEAR.
- Any `i_cs` access during CLEAR is ignored (no read, no write) and `o_error` pulses.

General:
- `o_error` is registered and high for exactly one cycle per offending access. Back-to-back offending accesses keep it high on consecutive cycles.
- Asynchronous `i_reset` forces IDLE, counter = 0, `o_dat` = 0, `o_error` = 0, `o_busy` = 0. Array contents are not reset.
- `i_reset` during CLEAR aborts the sweep. Words not yet reached keep their old values.

## Timing
- Read latency is 1 cycle: address sampled at edge N, data valid on `o_dat` after edge N, held until the next read or clear.
- A write at edge N followed by a read of the same address at edge N+1 returns the new data.
- `o_error` asserts in the cycle after the offending access is sampled.
- `o_busy` rises in the cycle after `i_mem_reset` is sampled in IDLE.
- Sweep duration is exactly `ROM_DEPTH` cycles of `o_busy` = 1; `o_busy` falls the cycle after the last word is cleared.
- The first access is accepted on the edge after `o_busy` falls.
- All outputs are driven from flops; there are no combinational paths from input to output.

## Configuration
- `MEST_IMEM_WRPROT_EN` defined:
  - A write with `i_addr` < `PROT_WORDS` is rejected: the array is unchanged and `o_error` pulses.
  - Reads of that region are allowed.
  - A CLEAR sweep still zeroes the protected region.
- `MEST_IMEM_WRPROT_EN` undefined: all in-range writes are accepted, and `PROT_WORDS` is ignored.

## Test plan
Bench parameters: `ROM_DEPTH`=16, `INSTRUCTION_SIZE`=28, `PROT_WORDS`=4.
- Write/read: write 0xABCDEF1 to addr 5, then read addr 5 on the next cycle → `o_dat` = 0xABCDEF1 one cycle after the read; `o_error` stays 0.
- Clear sweep: fill all 16 words with 0xFFFFFFF, pulse `i_mem_reset` for one cycle → `o_busy` high for exactly 16 cycles; afterwards reading each address returns 0.
- Access during clear: `i_cs` read at addr 3 on cycle 4 of the sweep → `o_error` pulses once; `o_dat` stays 0; sweep end time unchanged.
- Restart and reset: re-assert `i_mem_reset` on cycle 10 of the sweep → `o_busy` lasts 10+16 cycles. Separately, assert `i_reset` mid-sweep → `o_busy`, `o_dat` and `o_error` = 0 immediately, and unswept words retain 0xFFFFFFF.
- Protection: write 0x1234567 to addr 2 → with `MEST_IMEM_WRPROT_EN`, `o_error` pulses and reading addr 2 returns its old value; without the macro, reading addr 2 returns 0x1234567 and `o_error` = 0.
- Out-of-range: with `ROM_DEPTH`=12, read addr 13 → `o_error` pulses and `o_dat` holds its previous value.

Source files
------------

// File: rtl/mest_pro_imem_if.sv
// Memory-port bundle between mest_pro and its instruction/data memory responder.
// The processor drives the master side; the responder implements the slave side.
interface mest_pro_imem_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 28
);
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_in_dat;
  logic              i_cs;
  logic              i_we;
  logic              i_mem_reset;
  logic [DATA_W-1:0] o_dat;
  logic              o_error;
  logic              o_busy;

  modport master (
    output i_addr, i_in_dat, i_cs, i_we, i_mem_reset,
    input  o_dat, o_error, o_busy
  );

  modport slave (
    input  i_addr, i_in_dat, i_cs, i_we, i_mem_reset,
    output o_dat, o_error, o_busy
  );
endinterface

// File: rtl/mest_pro_imem_responder.sv
// Memory-side responder for the MEST Pro memory port: registered reads, writes, error pulses and
// a full-array clear sweep. Define MEST_IMEM_WRPROT_EN to reject writes below PROT_WORDS.
//
// state   | meaning
// S_IDLE  | serving reads/writes, flagging out-of-range (and protected) accesses
// S_CLEAR | zeroing one word per cycle from index 0 to ROM_DEPTH-1; accesses rejected
module mest_pro_imem_responder #(
  parameter int OP_CODE_SIZE     = 4,
  parameter int INSTRUCTION_SIZE = OP_CODE_SIZE + 24,
  parameter int ROM_DEPTH        = 65536,
  parameter int PROT_WORDS       = 16
) (
  input  logic            clk,
  input  logic            i_reset,
  mest_pro_imem_if.slave  bus
);
  localparam int ADDR_W = $clog2(ROM_DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(ROM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ROM_DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           cnt_q, cnt_d;
  logic [INSTRUCTION_SIZE-1:0] dat_q, dat_d;
  logic                        err_q, err_d;
  logic                        busy_q, busy_d;

  logic [INSTRUCTION_SIZE-1:0] mem_q [ROM_DEPTH];
  logic                        mem_we;
  logic [ADDR_W-1:0]           mem_waddr;
  logic [INSTRUCTION_SIZE-1:0] mem_wdata;

  logic in_range;
  logic prot_hit;

  // Compare one bit wider so non-power-of-two depths reject the unused top addresses.
  assign in_range = ({1'b0, bus.i_addr} < DEPTH_W);

`ifdef MEST_IMEM_WRPROT_EN
  localparam logic [ADDR_W:0] PROT_W = (ADDR_W+1)'(PROT_WORDS);
  assign prot_hit = bus.i_we && ({1'b0, bus.i_addr} < PROT_W);
`else
  assign prot_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dat_d     = dat_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = bus.i_addr;
    mem_wdata = bus.i_in_dat;
    case (state_q)
      S_IDLE: begin
        if (bus.i_mem_reset) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          dat_d   = '0;
        end else if (bus.i_cs) begin
          if (!in_range || prot_hit) begin
            err_d = 1'b1;
          end else if (bus.i_we) begin
            mem_we = 1'b1;
          end else begin
            dat_d = mem_q[bus.i_addr];
          end
        end
      end
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        if (bus.i_mem_reset) begin
          cnt_d = '0;
        end else begin
          err_d = bus.i_cs;
          if (cnt_q == LAST_IDX) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CLEAR);
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dat_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Array contents survive i_reset, so the storage has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.o_dat   = dat_q;
  assign bus.o_error = err_q;
  assign bus.o_busy  = busy_q;
endmodule

// File: tb/tb_mest_pro_imem_responder.sv
// Self-checking bench for mest_pro_imem_responder: a 16-word instance for data/clear/protection
// behaviour and a 12-word instance for out-of-range addressing, against an array-based model.
module tb_mest_pro_imem_responder;
  localparam int DW = 28;
  localparam int AW = 4;
`ifdef MEST_IMEM_WRPROT_EN
  localparam bit WRPROT = 1'b1;
`else
  localparam bit WRPROT = 1'b0;
`endif

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mest_pro_imem_if #(.ADDR_W(AW), .DATA_W(DW)) bus  ();
  mest_pro_imem_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

  mest_pro_imem_responder #(.OP_CODE_SIZE(4), .ROM_DEPTH(16), .PROT_WORDS(4)) dut (
    .clk(clk), .i_reset(rst), .bus(bus));
  mest_pro_imem_responder #(.OP_CODE_SIZE(4), .ROM_DEPTH(12), .PROT_WORDS(4)) dut2 (
    .clk(clk), .i_reset(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mm  [16];
  logic [DW-1:0] mm2 [12];
  logic [DW-1:0] exp_dat;
  logic [DW-1:0] exp2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic prot(input int a);
    return WRPROT && (a < 4);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_cs = 1'b0;  bus.i_we = 1'b0;  bus.i_mem_reset = 1'b0;
    bus2.i_cs = 1'b0; bus2.i_we = 1'b0; bus2.i_mem_reset = 1'b0;
  endtask

  task automatic acc(input logic we, input int a, input logic [DW-1:0] d);
    bus.i_cs = 1'b1; bus.i_we = we; bus.i_addr = AW'(a); bus.i_in_dat = d;
    cyc();
    idle();
  endtask

  task automatic mwrite(input int a, input logic [DW-1:0] d, input string tag);
    acc(1'b1, a, d);
    check({tag, "_err"}, 32'(bus.o_error), 32'(prot(a)));
    check({tag, "_dat"}, 32'(bus.o_dat), 32'(exp_dat));
    if (!prot(a)) mm[a] = d;
  endtask

  task automatic mread(input int a, input string tag);
    acc(1'b0, a, '0);
    exp_dat = mm[a];
    check({tag, "_dat"}, 32'(bus.o_dat), 32'(exp_dat));
    check({tag, "_err"}, 32'(bus.o_error), 32'd0);
  endtask

  task automatic fill_ones();
    for (int i = 0; i < 16; i++) mwrite(i, 28'hFFFFFFF, $sformatf("fill%0d", i));
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 16; i++) mread(i, $sformatf("%s%0d", tag, i));
  endtask

  // Pulse the clear request, then count busy cycles; optionally inject a read or a restart.
  task automatic sweep(input int acc_cyc, input int rst_cyc,
                       output int blen, output int ecnt, output int dbad);
    blen = 0; ecnt = 0; dbad = 0;
    bus.i_mem_reset = 1'b1;
    cyc();
    idle();
    while (bus.o_busy === 1'b1 && blen < 100) begin
      blen++;
      if (blen == acc_cyc) begin
        bus.i_cs = 1'b1; bus.i_we = 1'b0; bus.i_addr = 4'd3;
      end
      if (blen == rst_cyc) bus.i_mem_reset = 1'b1;
      cyc();
      idle();
      if (bus.o_error === 1'b1) ecnt++;
      if (bus.o_dat !== '0) dbad++;
    end
    for (int i = 0; i < 16; i++) mm[i] = '0;
    exp_dat = '0;
  endtask

  task automatic acc2(input logic we, input int a, input logic [DW-1:0] d, input string tag);
    bus2.i_cs = 1'b1; bus2.i_we = we; bus2.i_addr = AW'(a); bus2.i_in_dat = d;
    cyc();
    idle();
    if (a < 12) begin
      if (we) mm2[a] = d;
      else    exp2 = mm2[a];
    end
    check({tag, "_err"}, 32'(bus2.o_error), 32'(a >= 12));
    check({tag, "_dat"}, 32'(bus2.o_dat), 32'(exp2));
  endtask

  initial begin
    int blen, ecnt, dbad;
    vectors = 0; miscompares = 0;
    exp_dat = '0; exp2 = '0;
    rst = 1'b1;
    idle();
    bus.i_addr = '0;  bus.i_in_dat = '0;
    bus2.i_addr = '0; bus2.i_in_dat = '0;
    #12;
    check("rst_dat",   32'(bus.o_dat),    32'd0);
    check("rst_err",   32'(bus.o_error),  32'd0);
    check("rst_busy",  32'(bus.o_busy),   32'd0);
    check("rst2_dat",  32'(bus2.o_dat),   32'd0);
    check("rst2_err",  32'(bus2.o_error), 32'd0);
    check("rst2_busy", 32'(bus2.o_busy),  32'd0);
    rst = 1'b0;
    cyc();

    mwrite(5, 28'hABCDEF1, "wr5");
    mread(5, "rd5");
    check("rd5_const", 32'(bus.o_dat), 32'h0ABCDEF1);

    fill_ones();
    sweep(0, 0, blen, ecnt, dbad);
    check("clr_busy_len", 32'(blen), 32'd16);
    check("clr_err_cnt",  32'(ecnt), 32'd0);
    check("clr_dat",      32'(dbad), 32'd0);
    read_all("clr_rd");

    for (int n = 0; n < 40; n++) begin
      int r, a;
      logic [DW-1:0] d;
      r = $urandom_range(0, 3);
      a = $urandom_range(0, 15);
      d = DW'($urandom);
      if (r == 0) begin
        bus.i_addr = AW'(a); bus.i_we = d[0];
        cyc();
        idle();
        check("rnd_idle_dat", 32'(bus.o_dat),   32'(exp_dat));
        check("rnd_idle_err", 32'(bus.o_error), 32'd0);
      end else if (r == 1) begin
        mwrite(a, d, "rnd_wr");
      end else begin
        mread(a, "rnd_rd");
      end
    end

    fill_ones();
    sweep(4, 0, blen, ecnt, dbad);
    check("acc_busy_len", 32'(blen), 32'd16);
    check("acc_err_cnt",  32'(ecnt), 32'd1);
    check("acc_dat",      32'(dbad), 32'd0);
    read_all("acc_rd");

    fill_ones();
    sweep(0, 10, blen, ecnt, dbad);
    check("rs_busy_len", 32'(blen), 32'd26);
    check("rs_err_cnt",  32'(ecnt), 32'd0);
    read_all("rs_rd");

    fill_ones();
    bus.i_mem_reset = 1'b1;
    cyc();
    idle();
    check("mid_busy_on", 32'(bus.o_busy), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) begin
        bus.i_cs = 1'b1; bus.i_we = 1'b0; bus.i_addr = 4'd9;
      end
      cyc();
      idle();
    end
    check("mid_err_pre",  32'(bus.o_error), 32'd1);
    check("mid_busy_pre", 32'(bus.o_busy),  32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus.o_busy),  32'd0);
    check("mid_rst_dat",  32'(bus.o_dat),   32'd0);
    check("mid_rst_err",  32'(bus.o_error), 32'd0);
    for (int i = 0; i < 6; i++) mm[i] = '0;
    exp_dat = '0;
    #2 rst = 1'b0;
    read_all("mid_rd");

    mwrite(2, 28'h1234567, "prot_wr");
    mread(2, "prot_rd");
    check("prot_val", 32'(bus.o_dat), WRPROT ? 32'h0 : 32'h01234567);

    for (int i = 0; i < 12; i++) acc2(1'b1, i, DW'($urandom), $sformatf("r12_fill%0d", i));
    acc2(1'b0, 7,  '0, "r12_rd7");
    acc2(1'b0, 13, '0, "r12_rd13");
    acc2(1'b0, 14, '0, "r12_rd14_b2b");
    acc2(1'b1, 12, 28'h1234567, "r12_wr12");
    for (int n = 0; n < 20; n++) begin
      int a;
      a = $urandom_range(0, 15);
      acc2($urandom_range(0, 1) == 1, a, DW'($urandom), "r12_rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
